// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing (pixel/line counters, syncs, markers, frame count).
module video_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int CW     = 10,
  parameter int FCW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  output logic [CW-1:0]  pixel_out,
  output logic [CW-1:0]  line_out,
  output logic           visible,
  output logic           hsync,
  output logic           vsync,
  output logic           line_end,
  output logic           frame_end,
  output logic [FCW-1:0] frame_cnt
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
  localparam logic [CW-1:0] HS_BEG = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_VIS + V_FP + V_SYNC);
  localparam logic HS_ACT = HS_POL != 0;
  localparam logic VS_ACT = VS_POL != 0;
  if (H_VIS == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || CW == 0 || FCW == 0) begin : g_zero_param
    $error("video_timing_gen: parameters must be non-zero");
  end
  if (CW >= 31 || (1 << CW) < MAX_TOTAL) begin : g_narrow_cw
    $error("video_timing_gen: CW too narrow for raster totals");
  end
  logic [CW-1:0]  pixel_q, pixel_d, line_q, line_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           h_last, v_last;
  assign h_last = pixel_q == H_LAST;
  assign v_last = line_q == V_LAST;
  always_comb begin
    pixel_d = !ce ? pixel_q : h_last ? '0 : pixel_q + CW'(1);
    line_d  = !(ce && h_last) ? line_q : v_last ? '0 : line_q + CW'(1);
    frame_d = (ce && h_last && v_last) ? frame_q + FCW'(1) : frame_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q <= '0;
      line_q  <= '0;
      frame_q <= '0;
    end else begin
      pixel_q <= pixel_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end
  // Flags decode the counter registers directly so they stay coherent with the shown position.
  assign pixel_out = pixel_q;
  assign line_out  = line_q;
  assign frame_cnt = frame_q;
  assign visible   = pixel_q < H_VIS_C && line_q < V_VIS_C;
  assign hsync     = (pixel_q >= HS_BEG && pixel_q < HS_END) ? HS_ACT : ~HS_ACT;
  assign vsync     = (line_q >= VS_BEG && line_q < VS_END) ? VS_ACT : ~VS_ACT;
  assign line_end  = h_last;
  assign frame_end = h_last && v_last;
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor of the VGA sync generator. Produces pixel/line counters, visible flag, hsync/vsync, line/frame markers and a frame counter for any raster mode.
- Mode is set by front-porch/sync/back-porch parameters, with selectable sync polarity.
- Runs on the system clock, advanced by a pixel clock-enable. The line counter is not clocked from a derived signal.
- Feeds the pixel/pattern generator and the VGA output pins.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- VS_POL, 0, vsync active level
- CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
- FCW, 8, frame counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ce  in  1  pixel enable; timing advances one pixel per clk with ce=1
- pixel_out  out  CW  current pixel index in line, 0..H_TOTAL-1
- line_out  out  CW  current line index in frame, 0..V_TOTAL-1
- visible  out  1  high when pixel_out < H_VIS and line_out < V_VIS
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- line_end  out  1  high while pixel_out == H_TOTAL-1
- frame_end  out  1  high while pixel_out == H_TOTAL-1 and line_out == V_TOTAL-1
- frame_cnt  out  FCW  completed-frame count, wraps

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP = 800 and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP = 525 at defaults.
- Elaboration error if CW is too narrow or any parameter is 0.
- Counters count up.
- On clk rising with ce=1:
  - pixel_out increments.
  - At H_TOTAL-1, pixel_out wraps to 0 and line_out increments in the same edge.
  - At line_out == V_TOTAL-1 with pixel wrap, line_out wraps to 0 and frame_cnt increments (modulo 2^FCW).
- ce=0: every register holds, and all outputs are stable.
- All outputs are registers, or pure decodes of registers only (no ce in the output path). Outputs are always coherent with the pixel_out/line_out shown in the same cycle, so the latency from counter to flags is 0 cycles.
- hsync is active when H_VIS+H_FP <= pixel_out < H_VIS+H_FP+H_SYNC, and inactive otherwise.
- vsync is active when V_VIS+V_FP <= line_out < V_VIS+V_FP+V_SYNC.
- vsync changes only at line boundaries (on the pixel wrap edge).
- line_end and frame_end are levels: each lasts as long as the counter sits on the last pixel, i.e. until the next ce edge.
- Reset (rst=0, asynchronous, any time including mid-frame):
  - pixel_out=0, line_out=0, frame_cnt=0
  - visible=1, line_end=0, frame_end=0
  - hsync=~HS_POL, vsync=~VS_POL
- After release, the first ce edge moves to pixel 1. The partial frame before reset is discarded, with no frame_cnt increment.
- No other states. The pixel and line counters are the only state, plus frame_cnt.

Test Plan:
- Defaults, ce=1 continuously, release reset:
  - hsync=1 for pixel 0..655, 0 for 656..751, 1 for 752..799.
  - pixel_out goes 799 -> 0 with line_out 0 -> 1 on the same edge.
  - visible drops at pixel 640.
- Defaults, run 525 lines:
  - vsync=0 exactly on lines 490..491.
  - frame_end high on (799,524).
  - After 420000 ce cycles: pixel_out=0, line_out=0, frame_cnt=1.
- Small mode H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1, CW=4, FCW=2:
  - hsync=1 at pixels 10..11; vsync=1 on line 5.
  - frame_cnt wraps 3 -> 0 after 4 frames of 98 cycles each.
- ce toggled 1/0 every other clk (defaults):
  - One line takes 1600 clks.
  - Outputs never change on clks where ce was low on the preceding edge.
- Assert rst low mid-frame at (300,200), asynchronously between edges:
  - Outputs immediately become reset values (0, 0, visible=1, syncs inactive, frame_cnt=0).
  - After release, counting resumes from (0,0).
- ce=1 at pixel 799 of line 524:
  - line_end=1 and frame_end=1 in that cycle.
  - Next cycle: both 0, counters (0,0), frame_cnt incremented.
